// File: rtl/multi_fan_control.sv
// Multi-channel PWM fan controller on an Avalon-MM slave. Period and duty are double-buffered and applied at period boundaries.
// Define FAN_CTRL_RAMP_EN to compile in per-channel duty slew limiting (STEP per boundary).
module multi_fan_control #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 24,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW    = 4 + CH_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic                 read,
  output logic [31:0]          readdata,
  output logic                 waitrequest,
  input  logic [32*NUM_CH-1:0] current_average,
  output logic [NUM_CH-1:0]    pwm
);
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(50000);
  localparam logic [CH_W:0]    CH_LIMIT   = (CH_W+1)'(NUM_CH);

  logic [CH_W-1:0] ch_idx;
  logic [3:0]      reg_idx;
  logic            ch_ok;
  logic            rd_done;
  logic [31:0]     rd_val;

  logic [NUM_CH-1:0][CNT_W-1:0] period_rd, duty_rd, step_rd, applied_rd;
  logic [NUM_CH-1:0][2:0]       ctrl_rd;
  logic [NUM_CH-1:0][4:0]       shift_rd;

  assign ch_idx  = address[AW-1:4];
  assign reg_idx = address[3:0];
  assign ch_ok   = {1'b0, ch_idx} < CH_LIMIT;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0]   period_sh, duty_sh, period_act, duty_act, cnt;
    logic [CNT_W-1:0]   target, duty_next, step;
    logic [2:0]         ctrl;
    logic [4:0]         shift;
    logic signed [31:0] avg, avg_shifted;
    logic               wr_sel, active, pwm_q;

    assign wr_sel      = write && ch_ok && (ch_idx == CH_W'(i));
    assign avg         = current_average[32*i +: 32];
    assign avg_shifted = avg >>> shift;
    assign active      = ctrl[0] && (period_act != '0);

    always_comb begin
      target = duty_sh;
      if (ctrl[1]) begin
        if (avg_shifted[31])
          target = '0;
        else if ({1'b0, avg_shifted} > 33'(period_sh))
          target = period_sh;
        else
          target = CNT_W'(avg_shifted);
      end
    end

`ifdef FAN_CTRL_RAMP_EN
    // Move toward the target by at most STEP; differences are formed so they never wrap.
    always_comb begin
      duty_next = target;
      if (step != '0) begin
        if (target > duty_act) begin
          if (target - duty_act > step) duty_next = duty_act + step;
        end else if (duty_act - target > step) begin
          duty_next = duty_act - step;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        step <= '0;
      else if (wr_sel && reg_idx == 4'd4)
        step <= CNT_W'(writedata);
    end
`else
    assign duty_next = target;
    assign step      = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        period_sh  <= PERIOD_RST;
        duty_sh    <= '0;
        ctrl       <= '0;
        shift      <= '0;
        period_act <= PERIOD_RST;
        duty_act   <= '0;
        cnt        <= '0;
        pwm_q      <= 1'b0;
      end else begin
        if (wr_sel) begin
          case (reg_idx)
            4'd0:    period_sh <= CNT_W'(writedata);
            4'd1:    duty_sh   <= CNT_W'(writedata);
            4'd2:    ctrl      <= writedata[2:0];
            4'd3:    shift     <= writedata[4:0];
            default: ;
          endcase
        end
        if (active) begin
          pwm_q <= (cnt < duty_act) ^ ctrl[2];
          if (cnt == period_act - CNT_W'(1)) begin
            cnt        <= '0;
            period_act <= period_sh;
            duty_act   <= duty_next;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          // Idle channels track the shadow so enabling starts cleanly at cnt 0.
          cnt        <= '0;
          period_act <= period_sh;
          duty_act   <= target;
          pwm_q      <= ctrl[2];
        end
      end
    end

    assign period_rd[i]  = period_sh;
    assign duty_rd[i]    = duty_sh;
    assign ctrl_rd[i]    = ctrl;
    assign shift_rd[i]   = shift;
    assign step_rd[i]    = step;
    assign applied_rd[i] = duty_act;
    assign pwm[i]        = pwm_q;
  end

  always_comb begin
    rd_val = '0;
    if (ch_ok) begin
      case (reg_idx)
        4'd0:    rd_val = 32'(period_rd[ch_idx]);
        4'd1:    rd_val = 32'(duty_rd[ch_idx]);
        4'd2:    rd_val = 32'(ctrl_rd[ch_idx]);
        4'd3:    rd_val = 32'(shift_rd[ch_idx]);
        4'd4:    rd_val = 32'(step_rd[ch_idx]);
        4'd5:    rd_val = 32'(applied_rd[ch_idx]);
        4'd6:    rd_val = current_average[{ch_idx, 5'd0} +: 32];
        default: rd_val = '0;
      endcase
    end
  end

  // One wait state: data is captured on the first read cycle, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_done  <= 1'b0;
      readdata <= '0;
    end else begin
      rd_done <= read && !rd_done;
      if (read && !rd_done) readdata <= rd_val;
    end
  end

  assign waitrequest = read && !rd_done;

endmodule

// File: tb/tb_multi_fan_control.sv
// Self-checking bench for multi_fan_control: directed scenarios plus random bus traffic against a behavioural model.
`timescale 1ns/1ps
module tb_multi_fan_control;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 24;
  localparam int AW     = 6;
`ifdef FAN_CTRL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [AW-1:0]        address;
  logic                 write, read;
  logic [31:0]          writedata, readdata;
  logic                 waitrequest;
  logic [32*NUM_CH-1:0] current_average;
  logic [NUM_CH-1:0]    pwm;
  logic signed [31:0]   avg_in [NUM_CH];

  int checks = 0;
  int failures = 0;

  longint m_period [NUM_CH], m_duty [NUM_CH], m_ctrl [NUM_CH], m_shift [NUM_CH], m_step [NUM_CH];
  longint m_pact [NUM_CH], m_dact [NUM_CH], m_pos [NUM_CH];
  logic [NUM_CH-1:0] m_pwm;

  multi_fan_control #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .waitrequest(waitrequest),
    .current_average(current_average), .pwm(pwm)
  );

  always #5 clk = ~clk;

  always_comb begin
    current_average = '0;
    for (int i = 0; i < NUM_CH; i++) current_average[32*i +: 32] = avg_in[i];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_period[i] = 50000; m_duty[i] = 0; m_ctrl[i] = 0; m_shift[i] = 0; m_step[i] = 0;
      m_pact[i] = 50000; m_dact[i] = 0; m_pos[i] = 0;
    end
    m_pwm = '0;
  endtask

  // Auto target: floor(avg / 2^shift), limited to [0, PERIOD].
  function automatic longint target_of(int ch);
    longint a;
    if (((m_ctrl[ch] >> 1) & 1) == 0) return m_duty[ch];
    a = longint'(avg_in[ch]);
    if (a < 0) return 0;
    a = a / (longint'(1) << m_shift[ch]);
    return (a > m_period[ch]) ? m_period[ch] : a;
  endfunction

  function automatic longint ramp_of(longint cur, longint tgt, longint step);
    if (!RAMP || step == 0) return tgt;
    if (tgt > cur + step) return cur + step;
    if (tgt < cur - step) return cur - step;
    return tgt;
  endfunction

  function automatic logic [31:0] exp_read(int ch, int r);
    if (ch >= NUM_CH) return 0;
    case (r)
      0: return 32'(m_period[ch]);
      1: return 32'(m_duty[ch]);
      2: return 32'(m_ctrl[ch]);
      3: return 32'(m_shift[ch]);
      4: return 32'(m_step[ch]);
      5: return 32'(m_dact[ch]);
      6: return avg_in[ch];
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently presented.
  task automatic model_step();
    int ch, r;
    logic inv;
    longint tgt;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      inv = ((m_ctrl[i] >> 2) & 1) != 0;
      tgt = target_of(i);
      if ((m_ctrl[i] & 1) != 0 && m_pact[i] != 0) begin
        m_pwm[i] = (m_pos[i] < m_dact[i]) ^ inv;
        if (m_pos[i] == m_pact[i] - 1) begin
          m_pos[i] = 0; m_pact[i] = m_period[i]; m_dact[i] = ramp_of(m_dact[i], tgt, m_step[i]);
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end else begin
        m_pos[i] = 0; m_pact[i] = m_period[i]; m_dact[i] = tgt; m_pwm[i] = inv;
      end
    end
    if (write) begin
      ch = int'(address[5:4]);
      r  = int'(address[3:0]);
      if (ch < NUM_CH) begin
        case (r)
          0: m_period[ch] = longint'(writedata[CNT_W-1:0]);
          1: m_duty[ch]   = longint'(writedata[CNT_W-1:0]);
          2: m_ctrl[ch]   = longint'(writedata[2:0]);
          3: m_shift[ch]  = longint'(writedata[4:0]);
          4: if (RAMP) m_step[ch] = longint'(writedata[CNT_W-1:0]);
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("pwm", 32'(pwm), 32'(m_pwm));
  endtask

  task automatic bus_write(input int ch, input int r, input logic [31:0] d);
    address = AW'(ch*16 + r); writedata = d; write = 1'b1;
    cycle();
    write = 1'b0;
  endtask

  task automatic bus_read(input int ch, input int r, input bit with_wr, input logic [31:0] wd,
                          output logic [31:0] d);
    logic [31:0] exp;
    address = AW'(ch*16 + r); read = 1'b1; write = with_wr; writedata = wd;
    #1;
    exp = exp_read(ch, r);
    check_eq("wait_first", 32'(waitrequest), 1);
    cycle();
    write = 1'b0;
    check_eq("wait_second", 32'(waitrequest), 0);
    check_eq($sformatf("rd ch%0d reg%0d", ch, r), readdata, exp);
    d = readdata;
    cycle();
    read = 1'b0;
  endtask

  task automatic wait_pos(input int ch, input longint p, input int limit);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_pos[ch] != p && n < limit);
    check_eq($sformatf("wait_pos ch%0d", ch), 32'(m_pos[ch]), 32'(p));
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (pwm[ch]) hi++;
    end
  endtask

  function automatic logic [31:0] rand_data(int r);
    logic [31:0] hi_bits;
    hi_bits = $urandom & 32'hFF00_0000;
    case (r)
      0: return hi_bits | $urandom_range(0, 40);
      1: return hi_bits | $urandom_range(0, 50);
      4: return hi_bits | $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] ramp_exp;
    int hi, kind, ch, r;

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    for (int i = 0; i < NUM_CH; i++) avg_in[i] = 0;
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    check_eq("rst_pwm", 32'(pwm), 0);
    check_eq("rst_readdata", readdata, 0);
    check_eq("rst_wait", 32'(waitrequest), 0);
    bus_read(0, 0, 1'b0, 0, d);
    check_eq("rst_period0", d, 50000);
    bus_read(1, 2, 1'b0, 0, d);
    check_eq("rst_ctrl1", d, 0);

    // ch1 manual 25/100, then a mid-period duty change
    bus_write(1, 0, 100); bus_write(1, 1, 25); bus_write(1, 2, 1);
    wait_pos(1, 50, 300);
    count_high(1, 200, hi);
    check_eq("ch1_duty25", hi, 50);
    wait_pos(1, 10, 300);
    bus_write(1, 1, 60);
    bus_read(1, 5, 1'b0, 0, d);
    check_eq("ch1_applied_held", d, 25);
    wait_pos(1, 0, 200);
    wait_pos(1, 5, 20);
    count_high(1, 100, hi);
    check_eq("ch1_duty60", hi, 60);

    // ch2 inverted extremes
    bus_write(2, 1, 0); bus_write(2, 0, 100); bus_write(2, 2, 5);
    repeat (3) cycle();
    count_high(2, 150, hi);
    check_eq("ch2_inv_duty0", hi, 150);
    bus_write(2, 1, 200);
    repeat (110) cycle();
    count_high(2, 150, hi);
    check_eq("ch2_inv_duty_over", hi, 0);

    // ch0 automatic mode
    avg_in[0] = 8000;
    bus_write(0, 3, 4); bus_write(0, 0, 1000); bus_write(0, 2, 3);
    wait_pos(0, 0, 1100); wait_pos(0, 5, 20);
    bus_read(0, 5, 1'b0, 0, d);
    check_eq("auto_8000", d, 500);
    avg_in[0] = -5;
    wait_pos(0, 0, 1100); wait_pos(0, 5, 20);
    bus_read(0, 5, 1'b0, 0, d);
    check_eq("auto_neg", d, 0);
    avg_in[0] = 32000;
    wait_pos(0, 0, 1100); wait_pos(0, 5, 20);
    bus_read(0, 5, 1'b0, 0, d);
    check_eq("auto_clamp", d, 1000);
    bus_read(0, 6, 1'b0, 0, d);
    check_eq("avg_raw", d, 32000);

    // ch1 ramp (or immediate jump without slew limiting)
    bus_write(1, 1, 0);
    wait_pos(1, 0, 200); wait_pos(1, 3, 20);
    bus_read(1, 5, 1'b0, 0, d);
    check_eq("ramp_start", d, 0);
    bus_write(1, 4, 10); bus_write(1, 1, 35);
    bus_read(1, 4, 1'b0, 0, d);
    check_eq("step_reg", d, RAMP ? 10 : 0);
    for (int k = 0; k < 4; k++) begin
      wait_pos(1, 0, 200); wait_pos(1, 3, 20);
      bus_read(1, 5, 1'b0, 0, d);
      ramp_exp = RAMP ? ((k < 3) ? 32'(10 * (k + 1)) : 32'd35) : 32'd35;
      check_eq($sformatf("ramp_applied%0d", k), d, ramp_exp);
    end

    // same-cycle read and write, wide data truncation, invalid channel and registers
    bus_read(1, 1, 1'b1, 77, d);
    check_eq("rw_pre_write", d, 35);
    bus_read(1, 1, 1'b0, 0, d);
    check_eq("rw_post_write", d, 77);
    bus_write(2, 3, 32'hFFFF_FFE3);
    bus_read(2, 3, 1'b0, 0, d);
    check_eq("shift_trunc", d, 3);
    bus_write(3, 0, 55);
    bus_read(3, 0, 1'b0, 0, d);
    check_eq("bad_channel", d, 0);
    bus_read(0, 9, 1'b0, 0, d);
    check_eq("reserved_reg", d, 0);

    // random traffic against the model
    for (int op = 0; op < 400; op++) begin
      kind = $urandom_range(0, 9);
      ch   = $urandom_range(0, 3);
      r    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 6);
      if (kind < 5) begin
        bus_write(ch, r, rand_data(r));
      end else if (kind < 8) begin
        bus_read(ch, r, 1'($urandom_range(0, 1)), rand_data(r), d);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          case ($urandom_range(0, 2))
            0: avg_in[i] = $urandom;
            1: avg_in[i] = $urandom_range(0, 1000);
            default: avg_in[i] = -$signed($urandom_range(0, 100));
          endcase
        end
        repeat ($urandom_range(1, 30)) cycle();
      end
    end

    // asynchronous reset while ch1 output is high
    bus_write(1, 4, 0); bus_write(1, 0, 100); bus_write(1, 1, 50); bus_write(1, 2, 1);
    wait_pos(1, 0, 300);
    wait_pos(1, 10, 300);
    check_eq("pre_reset_pwm1", 32'(pwm[1]), 1);
    #2 reset = 1'b1;
    #1 check_eq("async_reset_pwm", 32'(pwm), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_read(1, 0, 1'b0, 0, d);
    check_eq("post_reset_period1", d, 50000);
    bus_read(1, 2, 1'b0, 0, d);
    check_eq("post_reset_ctrl1", d, 0);
    count_high(1, 20, hi);
    check_eq("post_reset_pwm1", hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_fan_control.md
# multi_fan_control

Parametrised multi-channel PWM fan controller behind an Avalon-MM slave. Each channel has its own period and duty (in clock ticks), double-buffered so that updates take effect only at a period boundary. An optional automatic mode derives duty from a per-channel signed current-average input using shift scaling instead of division. It replaces the single-channel fan controller in the PWM control subsystem and connects to the HPS lightweight bridge.

## Interface
- `NUM_CH`, 4: number of PWM channels (1–16)
- `CNT_W`, 24: period/duty counter width in bits
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `address` in `4+log2(NUM_CH)` (min 5): `address[3:0]` selects the register; the upper bits select the channel
- `write` in 1: Avalon write strobe
- `writedata` in 32: write data
- `read` in 1: Avalon read strobe
- `readdata` out 32: read data, valid when `read && !waitrequest`
- `waitrequest` out 1: read stall
- `current_average` in `32*NUM_CH`: signed current measurement for channel n at bits `[32n+31:32n]`
- `pwm` out `NUM_CH`: registered PWM outputs

## Operation
- Register map per channel:
  - 0 `PERIOD`: shadow, `CNT_W` bits
  - 1 `DUTY`: shadow, manual target, `CNT_W` bits
  - 2 `CTRL`: bit0 enable, bit1 auto, bit2 invert
  - 3 `SHIFT`: 5 bits, auto scaling
  - 4 `STEP`: ramp step, `CNT_W` bits
  - 5 `APPLIED`: read-only, active duty
  - 6 `AVG`: read-only, raw `current_average`
  - Reads of 7–15 return 0; writes to 5–15 are ignored.
  - A channel index ≥ `NUM_CH` reads 0 and ignores writes.
- Write data wider than a field is truncated to the field width.
- Target duty:
  - Manual: `DUTY`.
  - Auto: `current_average >>> SHIFT`, clamped to 0 when negative and to `PERIOD` when above it.
- Per-channel counter `cnt`:
  - Increments while enabled and `period_act != 0`.
  - At `cnt == period_act-1` it wraps to 0; this is the boundary.
- At the boundary:
  - `period_act` is loaded from `PERIOD`.
  - `duty_act` is loaded from the target (or the ramped value; see Configuration).
- The raw PWM level is `cnt < duty_act`, then XORed with invert, then registered.
  - `duty_act >= period_act` gives a constant 1.
  - `duty_act == 0` gives a constant 0.
- Disabled channel (enable=0 or `period_act == 0`):
  - `cnt` is held at 0.
  - `pwm` is driven to the invert level.
  - `period_act` and `duty_act` load directly from the shadow/target every cycle.
- Setting enable from 0 to 1 starts at `cnt = 0` with the current shadow values.

## Timing
- Reset values:
  - `readdata` = 0, `waitrequest` = 0, `pwm` = 0.
  - All registers and counters = 0, except `PERIOD` = 50000 and `period_act` = 50000.
  - Channels are disabled at reset.
- Read handshake:
  - `waitrequest` is high in the first cycle of `read` and low in the second.
  - `readdata` is valid in the cycle `waitrequest` is low.
  - Read latency is fixed at 1 wait state. Back-to-back reads each take 2 cycles.
- Writes take no wait states. The register updates at the clock edge where `write` is high.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- A write to `PERIOD` or `DUTY` mid-period does not affect the current period. It applies at the next boundary, and the `pwm` output changes 1 cycle after that boundary.
- `pwm` lags the `cnt` comparison by exactly 1 cycle.
- Reset asserted mid-period clears immediately (asynchronously); `pwm` goes low without waiting for the boundary.
- Auto mode samples `current_average` at the boundary only.

## Configuration
- `FAN_CTRL_RAMP_EN` defined (slew limiting compiled in):
  - At each boundary, `duty_act` moves toward the target by at most `STEP` and never overshoots.
  - `STEP == 0` means an immediate jump.
- `FAN_CTRL_RAMP_EN` undefined:
  - `duty_act` equals the target at each boundary.
  - `STEP` reads 0 and writes to it are ignored.

## Test plan
- Reset, then read ch0 `PERIOD` → `readdata` = 50000 after 1 wait cycle; all `pwm` = 0.
- ch1: `PERIOD`=100, `DUTY`=25, `CTRL`=1 → `pwm[1]` high 25 cycles of every 100. Then write `DUTY`=60 at `cnt`=10 → the current period stays 25 high; the next period is 60 high.
- ch2: `CTRL`=0b101 (enable, invert), `DUTY`=0 → `pwm[2]` constantly 1. Then `DUTY`=200 with `PERIOD`=100 → `pwm[2]` constantly 0.
- ch0 auto: `SHIFT`=4, `PERIOD`=1000.
  - avg=8000 → `APPLIED` = 500 after the boundary.
  - avg=−5 → `APPLIED` = 0.
  - avg=32000 → `APPLIED` = 1000.
- With `FAN_CTRL_RAMP_EN`: `STEP`=10, manual `DUTY` changed from 0 to 35 → `APPLIED` reads 10, 20, 30, 35 over 4 boundaries. Without the macro → 35 after 1 boundary.
- Assert reset while `pwm[1]` is high → `pwm` = 0 immediately; after release, ch1 is disabled and `PERIOD` reads 50000.
